// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types for the ALU operand sequencer
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_XOR = 4'd2,
        OP_ADD = 4'd4,
        OP_SUB = 4'd5
    } alu_op_t;

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } seq_state_t;

    function automatic logic is_valid_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: is_valid_op = 1'b1;
            default:                                is_valid_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_debounce.sv
// rtl/alu_operand_sequencer_btn_debounce.sv - button synchronizer, debounce counter and press detector
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          cand;
    logic          level;
    logic          primed;
    logic [CW-1:0] cnt;

    // The first accepted level after reset only sets the baseline, so a
    // button held through reset never yields a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cand   <= 1'b0;
            level  <= 1'b0;
            primed <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CW'(DB_CYCLES - 1)) begin
                cnt <= cnt + 1'b1;
            end else begin
                level  <= cand;
                primed <= 1'b1;
                if (primed && cand && !level)
                    press <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - steps A/B/opcode loading from switches and captures ALU results
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [3:0]       op_sw,
    input  logic             btn,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_n,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result_q,
    output logic [3:0]       flags_q,
    output logic             valid,
    output logic             op_err,
    output logic [2:0]       state_q
);

    logic       press;
    seq_state_t state;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

    assign state_q = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOAD_A;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            valid       <= 1'b0;
            op_err      <= 1'b0;
        end else begin
            case (state)
                S_LOAD_A: if (press) begin
                    alu_a <= sw;
                    state <= S_LOAD_B;
                end
                S_LOAD_B: if (press) begin
                    alu_b <= sw;
                    state <= S_LOAD_OP;
                end
                S_LOAD_OP: if (press) begin
                    alu_control <= op_sw;
                    state       <= S_EXEC;
                end
                // Operands were registered on the previous edge, so the ALU output has settled.
                S_EXEC: begin
                    result_q <= alu_result;
                    flags_q  <= {alu_n, (alu_result == '0), alu_c, alu_v};
                    valid    <= 1'b1;
                    op_err   <= !is_valid_op(alu_control);
                    state    <= S_SHOW;
                end
                S_SHOW: if (press) begin
                    valid <= 1'b0;
                    state <= S_LOAD_A;
                end
                default: state <= S_LOAD_A;
            endcase
        end
    end

endmodule
